// File: rtl/filter_local_buffer.sv
// Word-addressed local buffer: one write port, NUM_RD independent read channels.
// Define FILTER_LOCAL_BUFFER_BYPASS_EN for write-first same-index forwarding.
module filter_local_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int L2_AWIDTH_NOAL = 15,
  parameter int DEPTH          = 1024,
  parameter int NUM_RD         = 2
) (
  input  logic                                clk_i,
  input  logic                                resetn_i,
  input  logic                                wr_valid_i,
  input  logic [L2_AWIDTH_NOAL-1:0]           wr_addr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  output logic                                wr_ready_o,
  input  logic [NUM_RD-1:0]                   rd_req_i,
  input  logic [NUM_RD*L2_AWIDTH_NOAL-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0]                   rd_gnt_o,
  output logic [NUM_RD-1:0]                   rd_valid_o,
  output logic [NUM_RD*DATA_WIDTH-1:0]        rd_data_o,
  input  logic [NUM_RD-1:0]                   rd_ready_i,
  input  logic                                clr_err_i,
  output logic                                oor_err_o
);

  localparam int IDX_W  = L2_AWIDTH_NOAL - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_IDX = (IDX_W + 1)'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rd_state_e;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_IDX;
  endfunction

  logic                  resetn_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic                  wr_fire;
  logic [NUM_RD-1:0]     rd_oor;
  logic                  unused_wr_lsb;

  assign wr_idx        = wr_addr_i[L2_AWIDTH_NOAL-1:2];
  assign wr_in_range   = idx_in_range(wr_idx);
  assign wr_fire       = wr_valid_i && resetn_q;
  assign wr_ready_o    = resetn_q;
  assign unused_wr_lsb = ^wr_addr_i[1:0];

  // Registered copy of reset release; gates both write acceptance and read grants.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      resetn_q <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset branch; contents survive resetn_i and
  // stay mappable to RAM, while all control state around it is reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire && wr_in_range) begin
      mem[wr_idx[MEM_AW-1:0]] <= wr_data_i;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rd_state_e             state;
    logic [DATA_WIDTH-1:0] resp;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic                  gnt;
    logic                  unused_rd_lsb;

    assign rd_idx        = rd_addr_i[k*L2_AWIDTH_NOAL+2 +: IDX_W];
    assign rd_in_range   = idx_in_range(rd_idx);
    assign unused_rd_lsb = ^rd_addr_i[k*L2_AWIDTH_NOAL +: 2];

    // A full slot may be refilled in the same cycle its word is consumed.
    assign gnt = rd_req_i[k] && resetn_q && ((state == EMPTY) || rd_ready_i[k]);

    // NOTE: rd_word gets a default before any conditional assignment so the
    // block stays purely combinational and never infers a latch.
    always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
        rd_word = mem[rd_idx[MEM_AW-1:0]];
      end
`ifdef FILTER_LOCAL_BUFFER_BYPASS_EN
      if (wr_fire && wr_in_range && (wr_idx == rd_idx)) begin
        rd_word = wr_data_i;
      end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every channel
    // samples the pre-edge memory and state values regardless of block order.
    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        state <= EMPTY;
        resp  <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (gnt) begin
              state <= FULL;
              resp  <= rd_word;
            end
          end
          FULL: begin
            if (gnt) begin
              resp <= rd_word;
            end else if (rd_ready_i[k]) begin
              state <= EMPTY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end

    assign rd_gnt_o[k]                         = gnt;
    assign rd_valid_o[k]                       = (state == FULL);
    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = resp;
    assign rd_oor[k]                           = gnt && !rd_in_range;
  end

  // Clear wins over a coincident out-of-range event.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      oor_err_o <= 1'b0;
    end else if (clr_err_i) begin
      oor_err_o <= 1'b0;
    end else if ((|rd_oor) || (wr_fire && !wr_in_range)) begin
      oor_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_filter_local_buffer.sv
// Directed bench for filter_local_buffer: stimulus pushes expected read data into
// per-channel queues, a negedge monitor pops and compares on every response handshake.
module tb_filter_local_buffer;

  localparam int DW    = 32;
  localparam int AW    = 15;
  localparam int DEPTH = 1024;
  localparam int NRD   = 2;

  logic              clk_i = 1'b0;
  logic              resetn_i = 1'b0;
  logic              wr_valid_i = 1'b0;
  logic [AW-1:0]     wr_addr_i = '0;
  logic [DW-1:0]     wr_data_i = '0;
  logic              wr_ready_o;
  logic [NRD-1:0]    rd_req_i = '0;
  logic [NRD*AW-1:0] rd_addr_i = '0;
  logic [NRD-1:0]    rd_gnt_o;
  logic [NRD-1:0]    rd_valid_o;
  logic [NRD*DW-1:0] rd_data_o;
  logic [NRD-1:0]    rd_ready_i = '1;
  logic              clr_err_i = 1'b0;
  logic              oor_err_o;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] model [int];

  always #5 clk_i = ~clk_i;

  filter_local_buffer #(
    .DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .DEPTH(DEPTH), .NUM_RD(NRD)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .clr_err_i(clr_err_i), .oor_err_o(oor_err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] val);
    if (ch == 0) exp_q0.push_back(val);
    else         exp_q1.push_back(val);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_valid_i = 1'b1;
    wr_addr_i  = addr;
    wr_data_i  = data;
    tick();
    wr_valid_i = 1'b0;
    model[int'(addr)] = data;
  endtask

  // Holds a request until granted (bounded), queuing the expected word at the grant.
  task automatic read1(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bit got = 1'b0;
    rd_req_i[ch] = 1'b1;
    rd_addr_i[ch*AW +: AW] = addr;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      if (rd_gnt_o[ch]) begin
        got = 1'b1;
        push(ch, exp);
      end
      tick();
    end
    rd_req_i[ch] = 1'b0;
    check("rd_grant_within_bound", 64'(got), 64'd1);
  endtask

  always @(negedge clk_i) begin
    if (resetn_i) begin
      if (rd_valid_o[0] && rd_ready_i[0]) begin
        if (exp_q0.size() == 0) check("ch0_unexpected_resp", 64'(rd_valid_o[0]), 64'd0);
        else                    check("ch0_data", 64'(rd_data_o[0 +: DW]), 64'(exp_q0.pop_front()));
      end
      if (rd_valid_o[1] && rd_ready_i[1]) begin
        if (exp_q1.size() == 0) check("ch1_unexpected_resp", 64'(rd_valid_o[1]), 64'd0);
        else                    check("ch1_data", 64'(rd_data_o[DW +: DW]), 64'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: requests held high must not be granted.
    rd_req_i = 2'b11;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd0);
    check("rst_gnt", 64'(rd_gnt_o), 64'd0);
    check("rst_valid", 64'(rd_valid_o), 64'd0);
    check("rst_data", 64'(rd_data_o), 64'd0);
    check("rst_oor", 64'(oor_err_o), 64'd0);
    rd_req_i = '0;
    resetn_i = 1'b1;
    #1;
    check("wr_ready_before_edge", 64'(wr_ready_o), 64'd0);
    tick();
    check("wr_ready_after_edge", 64'(wr_ready_o), 64'd1);

    // Basic write then read, latency one cycle after grant.
    do_write(15'h0010, 32'hA5A5_0001);
    read1(0, 15'h0010, 32'hA5A5_0001);
    check("rd_latency_valid", 64'(rd_valid_o[0]), 64'd1);
    check("rd_latency_data", 64'(rd_data_o[0 +: DW]), 64'hA5A5_0001);
    tick();

    // Fill 0x00..0x3C (keeping 0x10) and 0x40 with back-to-back writes.
    for (int i = 0; i < 16; i++) begin
      if (i != 4) do_write(AW'(i * 4), 32'h5A00_0000 | 32'(i));
    end
    do_write(15'h0040, 32'h0);

    // Low address bits are ignored.
    read1(1, 15'h0013, 32'hA5A5_0001);
    tick();

    // Channel 1 stalled by rd_ready_i[1]=0 for 5 cycles.
    rd_ready_i[1] = 1'b0;
    rd_req_i[1] = 1'b1;
    rd_addr_i[AW +: AW] = 15'h0020;
    @(negedge clk_i);
    check("stall_first_gnt", 64'(rd_gnt_o[1]), 64'd1);
    push(1, model[32'h20]);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("stall_gnt_low", 64'(rd_gnt_o[1]), 64'd0);
      check("stall_valid", 64'(rd_valid_o[1]), 64'd1);
      check("stall_data", 64'(rd_data_o[DW +: DW]), 64'(model[32'h20]));
      tick();
    end
    rd_ready_i[1] = 1'b1;
    @(negedge clk_i);
    check("stall_release_gnt", 64'(rd_gnt_o[1]), 64'd1);
    push(1, model[32'h20]);
    tick();
    rd_req_i[1] = 1'b0;
    tick();
    tick();

    // Both channels streaming 16 words back-to-back.
    for (int i = 0; i < 16; i++) begin
      rd_req_i  = 2'b11;
      rd_addr_i = {AW'(i * 4), AW'(i * 4)};
      @(negedge clk_i);
      check("stream_gnt", 64'(rd_gnt_o), 64'd3);
      if (i > 0) check("stream_valid", 64'(rd_valid_o), 64'd3);
      push(0, model[i * 4]);
      push(1, model[i * 4]);
      tick();
    end
    rd_req_i = '0;
    @(negedge clk_i);
    check("stream_last_valid", 64'(rd_valid_o), 64'd3);
    tick();
    @(negedge clk_i);
    check("stream_drained", 64'(rd_valid_o), 64'd0);
    tick();

    // Same-cycle write and read of index 0x40.
    wr_valid_i = 1'b1;
    wr_addr_i  = 15'h0040;
    wr_data_i  = 32'h1234_5678;
    rd_req_i[0] = 1'b1;
    rd_addr_i[0 +: AW] = 15'h0040;
    @(negedge clk_i);
    check("collide_gnt", 64'(rd_gnt_o[0]), 64'd1);
`ifdef FILTER_LOCAL_BUFFER_BYPASS_EN
    push(0, 32'h1234_5678);
`else
    push(0, 32'h0);
`endif
    tick();
    wr_valid_i = 1'b0;
    rd_req_i[0] = 1'b0;
    model[32'h40] = 32'h1234_5678;
    check("collide_valid", 64'(rd_valid_o[0]), 64'd1);
    tick();
    read1(0, 15'h0040, 32'h1234_5678);
    tick();

    // Out-of-range read, sticky flag and clear.
    check("oor_idle", 64'(oor_err_o), 64'd0);
    read1(0, 15'h1000, 32'h0);
    check("oor_set", 64'(oor_err_o), 64'd1);
    check("oor_rd_data", 64'(rd_data_o[0 +: DW]), 64'd0);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("oor_cleared", 64'(oor_err_o), 64'd0);
    wr_valid_i = 1'b1;
    wr_addr_i  = 15'h1000;
    wr_data_i  = 32'hDEAD_BEEF;
    clr_err_i  = 1'b1;
    tick();
    clr_err_i  = 1'b0;
    check("oor_clr_priority", 64'(oor_err_o), 64'd0);
    tick();
    wr_valid_i = 1'b0;
    check("oor_wr_set", 64'(oor_err_o), 64'd1);
    read1(0, 15'h0000, model[0]);
    tick();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;

    // Reset while channel 0 holds an unconsumed response.
    rd_ready_i[0] = 1'b0;
    rd_req_i[0] = 1'b1;
    rd_addr_i[0 +: AW] = 15'h0010;
    @(negedge clk_i);
    check("pre_reset_gnt", 64'(rd_gnt_o[0]), 64'd1);
    tick();
    rd_req_i[0] = 1'b0;
    check("pre_reset_full", 64'(rd_valid_o[0]), 64'd1);
    #2 resetn_i = 1'b0;
    #1;
    check("async_valid_clear", 64'(rd_valid_o[0]), 64'd0);
    check("async_data_clear", 64'(rd_data_o), 64'd0);
    check("async_wr_ready", 64'(wr_ready_o), 64'd0);
    tick();
    tick();
    resetn_i = 1'b1;
    rd_ready_i[0] = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    check("no_resp_after_reset", 64'(rd_valid_o), 64'd0);
    tick();
    read1(0, 15'h0010, 32'hA5A5_0001);
    tick();
    tick();

    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_local_buffer.md
FILTER_LOCAL_BUFFER -- requirements
Module: filter_local_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width of the buffer and of every data port.
REQ-002 SHALL have parameter L2_AWIDTH_NOAL, default 15: byte-address width of every address port.
REQ-003 SHALL have parameter DEPTH, default 1024: number of DATA_WIDTH words stored.
REQ-004 SHALL have parameter NUM_RD, default 2: number of independent read channels, legal range 1..8.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port resetn_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_valid_i, input, 1 bit: write request.
REQ-008 SHALL have port wr_addr_i, input, L2_AWIDTH_NOAL bits: write byte address.
REQ-009 SHALL have port wr_data_i, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port wr_ready_o, output, 1 bit: write accepted when high with wr_valid_i.
REQ-011 SHALL have port rd_req_i, input, NUM_RD bits: per-channel read request.
REQ-012 SHALL have port rd_addr_i, input, NUM_RD*L2_AWIDTH_NOAL bits: per-channel byte address, channel k in slice k.
REQ-013 SHALL have port rd_gnt_o, output, NUM_RD bits: per-channel grant; request accepted when rd_req_i and rd_gnt_o are both high.
REQ-014 SHALL have port rd_valid_o, output, NUM_RD bits: per-channel response valid.
REQ-015 SHALL have port rd_data_o, output, NUM_RD*DATA_WIDTH bits: per-channel response data, channel k in slice k.
REQ-016 SHALL have port rd_ready_i, input, NUM_RD bits: per-channel response consumed when high with rd_valid_o.
REQ-017 SHALL have port clr_err_i, input, 1 bit: synchronous clear of oor_err_o.
REQ-018 SHALL have port oor_err_o, output, 1 bit: sticky out-of-range access flag.

Function
REQ-019 SHALL map byte address A to word index A>>2; address bits [1:0] ignored.
REQ-020 SHALL treat word index >= DEPTH as out of range: write dropped, read returns all-zero data, oor_err_o set on the next edge.
REQ-021 SHALL accept one write per cycle; mem[index] updated at the edge where wr_valid_i && wr_ready_o.
REQ-022 SHALL drive wr_ready_o from a register: 0 in reset, 1 from the first rising edge after resetn_i deasserts.
REQ-023 SHALL implement per channel a two-state FSM EMPTY/FULL holding one response register.
REQ-024 SHALL drive rd_gnt_o[k] = rd_req_i[k] && resetn_q && (state EMPTY || rd_ready_i[k]), combinationally (resetn_q = the wr_ready_o register).
REQ-025 SHALL on grant at edge N load the response register with mem[index] as sampled at N; rd_valid_o[k] high from N+1 (latency 1).
REQ-026 SHALL transition EMPTY->FULL on grant; FULL->EMPTY on rd_ready_i without grant; FULL->FULL with reload on rd_ready_i with grant (back-to-back, one word per cycle).
REQ-027 SHALL hold rd_data_o[k] and rd_valid_o[k] stable while FULL and rd_ready_i[k] low.
REQ-028 SHALL serve all NUM_RD channels in the same cycle without mutual stall, including identical addresses.
REQ-029 SHALL, for read and write to the same index in the same cycle, return old data (read-before-write) unless REQ-035 applies.
REQ-030 SHALL give clr_err_i priority over a simultaneous new out-of-range event (flag cleared, event lost).

Reset
REQ-031 SHALL on resetn_i low immediately force wr_ready_o=0, rd_gnt_o=0, rd_valid_o=0, rd_data_o=0, oor_err_o=0, all FSMs EMPTY.
REQ-032 SHALL not reset memory contents; contents are retained across reset.
REQ-033 SHALL discard in-flight responses when reset asserts mid-transfer; no response emitted after reset.

Configuration
REQ-034 SHALL use macro FILTER_LOCAL_BUFFER_BYPASS_EN to select collision behaviour.
REQ-035 SHALL with FILTER_LOCAL_BUFFER_BYPASS_EN defined forward wr_data_i to any channel granted at the same edge and same in-range index (write-first); without it, REQ-029 applies.

Verification
REQ-036 SHALL cover: write 0xA5A5_0001 to 0x0010, ch0 req 0x0010 next cycle, rd_ready_i=1 -> rd_valid_o[0] one cycle after grant, data 0xA5A5_0001.
REQ-037 SHALL cover: ch1 req 0x0020 held with rd_ready_i[1]=0 for 5 cycles -> rd_gnt_o[1]=0 after first grant, rd_data_o[1] stable, released on ready.
REQ-038 SHALL cover: ch0 and ch1 streaming 0x0000..0x003C back-to-back, ready=1 -> 16 words each, one per cycle, no gaps, no stalls.
REQ-039 SHALL cover: same-cycle write 0x1234_5678 and ch0 read at 0x0040 over old 0x0 -> 0x0 without macro, 0x1234_5678 with FILTER_LOCAL_BUFFER_BYPASS_EN.
REQ-040 SHALL cover: DEPTH=1024, read 0x1000 -> data 0, oor_err_o=1 next cycle; clr_err_i pulse -> 0.
REQ-041 SHALL cover: resetn_i low while ch0 FULL -> rd_valid_o[0]=0 asynchronously; after release, memory word at 0x0010 still 0xA5A5_0001.
